// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - PC select codes and sequencer state encoding for the fetch controller
package fetch_ctrl_pkg;

    localparam logic [1:0] PC_SEL_PC4 = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JR  = 2'b10;
    localparam logic [1:0] PC_SEL_JAL = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT       = 2'd0,
        ST_RUN        = 2'd1,
        ST_IMISS      = 2'd2,
        ST_REDIR_PEND = 2'd3
    } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - hazard/redirect inputs and PC/IF-ID control outputs of the fetch controller
interface fetch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             Branch_Taken;
    logic             JR_D;
    logic             JAL_D;
    logic             ICache_Stall;
    logic             DCache_Stall;
    logic             Load_Use;
    logic [1:0]       PC_Sel;
    logic             PC_EN;
    logic             Flush_IF;
    logic             Flush_ID;
    logic             Stall_ID;
    logic             Hold_Branch;
    logic [CNT_W-1:0] Stall_Count;

    // master is the controller itself; slave is the pipeline side feeding hazards in
    modport master (
        input  Branch_Taken, JR_D, JAL_D, ICache_Stall, DCache_Stall, Load_Use,
        output PC_Sel, PC_EN, Flush_IF, Flush_ID, Stall_ID, Hold_Branch, Stall_Count
    );

    modport slave (
        output Branch_Taken, JR_D, JAL_D, ICache_Stall, DCache_Stall, Load_Use,
        input  PC_Sel, PC_EN, Flush_IF, Flush_ID, Stall_ID, Hold_Branch, Stall_Count
    );
endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// rtl/fetch_ctrl_sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC redirect arbiter and front-end freeze sequencer
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    fetch_ctrl_if.master     bus
);

    localparam int            BW        = $clog2(BOOT_CYCLES + 1);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic          pending;
    logic          pending_nx;
    logic [BW-1:0] boot_cnt;

    logic [1:0]    sel;
    logic          en;
    logic          fi;
    logic          fd;
    logic          sid;

    sat_counter #(.W(BW)) u_boot_cnt (
        .clk (CLK),
        .clr (RST || (state != ST_BOOT)),
        .inc ((state == ST_BOOT) && !bus.DCache_Stall),
        .q   (boot_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (!en),
        .q   (bus.Stall_Count)
    );

    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        sel        = PC_SEL_PC4;
        en         = 1'b1;
        fi         = 1'b0;
        fd         = 1'b0;
        sid        = 1'b0;

        if (RST) begin
            en  = 1'b0;
            sid = 1'b1;
        end else if (bus.DCache_Stall) begin
            // EX is frozen too, so a branch seen now is re-presented once the miss clears
            en  = 1'b0;
            sid = 1'b1;
            if (pending) sel = PC_SEL_BR;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    en  = 1'b0;
                    sid = 1'b1;
                    if (boot_cnt == BOOT_LAST) state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.Branch_Taken && bus.ICache_Stall) begin
                        en         = 1'b0;
                        fd         = 1'b1;
                        pending_nx = 1'b1;
                        state_nx   = ST_REDIR_PEND;
                    end else if (bus.Branch_Taken) begin
                        sel = PC_SEL_BR;
                        fi  = 1'b1;
                        fd  = 1'b1;
                    end else if (bus.ICache_Stall) begin
                        en       = 1'b0;
                        sid      = 1'b1;
                        state_nx = ST_IMISS;
                    end else if (bus.Load_Use) begin
                        en  = 1'b0;
                        sid = 1'b1;
                        fd  = 1'b1;
                    end else if (bus.JR_D) begin
                        sel = PC_SEL_JR;
                        fi  = 1'b1;
                    end else if (bus.JAL_D) begin
                        sel = PC_SEL_JAL;
                        fi  = 1'b1;
                    end
                end
                ST_IMISS: begin
                    if (!bus.ICache_Stall && bus.Branch_Taken) begin
                        sel      = PC_SEL_BR;
                        fi       = 1'b1;
                        fd       = 1'b1;
                        state_nx = ST_RUN;
                    end else begin
                        en  = 1'b0;
                        sid = 1'b1;
                        fd  = 1'b1;
                        if (bus.Branch_Taken) begin
                            pending_nx = 1'b1;
                            state_nx   = ST_REDIR_PEND;
                        end else if (!bus.ICache_Stall) begin
                            state_nx = ST_RUN;
                        end
                    end
                end
                ST_REDIR_PEND: begin
                    sel = PC_SEL_BR;
                    fd  = 1'b1;
                    if (bus.ICache_Stall) begin
                        en = 1'b0;
                    end else begin
                        fi         = 1'b1;
                        pending_nx = 1'b0;
                        state_nx   = ST_RUN;
                    end
                end
                default: begin
                    en       = 1'b0;
                    sid      = 1'b1;
                    state_nx = ST_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_BOOT;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
        end
    end

    assign bus.PC_Sel      = sel;
    assign bus.PC_EN       = en;
    assign bus.Flush_IF    = fi;
    assign bus.Flush_ID    = fd;
    assign bus.Stall_ID    = sid;
    assign bus.Hold_Branch = pending && !RST;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized and directed checks of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;

    localparam int BOOT = 2;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       fi;
        logic       fd;
        logic       sid;
        logic       hold;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    bit   check_en;

    fetch_ctrl_if #(.CNT_W(CW)) bus ();

    fetch_ctrl #(.BOOT_CYCLES(BOOT), .CNT_W(CW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: where the front end is, expressed as flags and a countdown
    bit booting;
    int boot_left;
    bit in_miss;
    bit branch_owed;
    int m_cnt;

    function automatic exp_t model_out(input logic r, input logic bt, input logic jr,
                                       input logic jal, input logic ic, input logic dc,
                                       input logic lu);
        exp_t e;
        e    = '0;
        e.en = 1'b1;
        if (r) begin
            e.en = 0; e.sid = 1;
        end else if (dc) begin
            e.en = 0; e.sid = 1;
            e.hold = branch_owed;
            e.sel  = branch_owed ? 2'b01 : 2'b00;
        end else if (booting) begin
            e.en = 0; e.sid = 1;
        end else if (branch_owed) begin
            e.sel = 2'b01; e.hold = 1; e.fd = 1;
            if (ic) e.en = 0;
            else    e.fi = 1;
        end else if (bt && !(in_miss && ic) && !(!in_miss && ic)) begin
            e.sel = 2'b01; e.fi = 1; e.fd = 1;
        end else if (in_miss) begin
            e.en = 0; e.sid = 1; e.fd = 1;
        end else if (bt) begin
            e.en = 0; e.fd = 1;
        end else if (ic) begin
            e.en = 0; e.sid = 1;
        end else if (lu) begin
            e.en = 0; e.sid = 1; e.fd = 1;
        end else if (jr) begin
            e.sel = 2'b10; e.fi = 1;
        end else if (jal) begin
            e.sel = 2'b11; e.fi = 1;
        end
        return e;
    endfunction

    function automatic exp_t cur_exp();
        return model_out(rst, bus.Branch_Taken, bus.JR_D, bus.JAL_D,
                         bus.ICache_Stall, bus.DCache_Stall, bus.Load_Use);
    endfunction

    exp_t ue;
    always @(posedge clk) begin
        ue = cur_exp();
        if (rst) begin
            booting = 1; boot_left = BOOT; in_miss = 0; branch_owed = 0; m_cnt = 0;
        end else begin
            if (!ue.en && m_cnt < CMAX) m_cnt = m_cnt + 1;
            if (bus.DCache_Stall) begin
                // everything frozen
            end else if (booting) begin
                boot_left = boot_left - 1;
                if (boot_left == 0) booting = 0;
            end else if (branch_owed) begin
                if (!bus.ICache_Stall) branch_owed = 0;
            end else if (bus.Branch_Taken && bus.ICache_Stall) begin
                branch_owed = 1; in_miss = 0;
            end else if (in_miss) begin
                if (!bus.ICache_Stall) in_miss = 0;
            end else if (bus.ICache_Stall && !bus.Branch_Taken) begin
                in_miss = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    exp_t ce;
    always @(negedge clk) begin
        if (check_en) begin
            ce = cur_exp();
            chk("PC_Sel",      32'(bus.PC_Sel),      32'(ce.sel));
            chk("PC_EN",       32'(bus.PC_EN),       32'(ce.en));
            chk("Flush_IF",    32'(bus.Flush_IF),    32'(ce.fi));
            chk("Flush_ID",    32'(bus.Flush_ID),    32'(ce.fd));
            chk("Stall_ID",    32'(bus.Stall_ID),    32'(ce.sid));
            chk("Hold_Branch", 32'(bus.Hold_Branch), 32'(ce.hold));
            chk("Stall_Count", 32'(bus.Stall_Count), 32'(m_cnt));
        end
    end

    task automatic set_in(input logic r, input logic bt, input logic jr, input logic jal,
                          input logic ic, input logic dc, input logic lu);
        rst              = r;
        bus.Branch_Taken = bt;
        bus.JR_D         = jr;
        bus.JAL_D        = jal;
        bus.ICache_Stall = ic;
        bus.DCache_Stall = dc;
        bus.Load_Use     = lu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; check_en = 0;
        set_in(1, 0, 0, 0, 0, 0, 0);

        // boot hold after a one-cycle reset
        probe();
        chk("rst_pc_en", 32'(bus.PC_EN), 0);
        chk("rst_stall_id", 32'(bus.Stall_ID), 1);
        chk("rst_hold", 32'(bus.Hold_Branch), 0);
        tick();
        check_en = 1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        probe(); chk("boot1_pc_en", 32'(bus.PC_EN), 0); tick();
        probe(); chk("boot2_pc_en", 32'(bus.PC_EN), 0); tick();
        probe();
        chk("run_pc_en", 32'(bus.PC_EN), 1);
        chk("run_pc_sel", 32'(bus.PC_Sel), 0);
        chk("boot_count", 32'(bus.Stall_Count), 2);
        tick();

        // branch beats JAL and load-use
        set_in(0, 1, 0, 1, 0, 0, 1);
        probe();
        chk("br_sel", 32'(bus.PC_Sel), 1);
        chk("br_en", 32'(bus.PC_EN), 1);
        chk("br_fi", 32'(bus.Flush_IF), 1);
        chk("br_fd", 32'(bus.Flush_ID), 1);
        tick();

        // load-use suppresses JR, then JR redirects
        set_in(0, 0, 1, 0, 0, 0, 1);
        probe();
        chk("lu_en", 32'(bus.PC_EN), 0);
        chk("lu_fd", 32'(bus.Flush_ID), 1);
        tick();
        set_in(0, 0, 1, 0, 0, 0, 0);
        probe();
        chk("jr_sel", 32'(bus.PC_Sel), 2);
        chk("jr_en", 32'(bus.PC_EN), 1);
        chk("jr_fi", 32'(bus.Flush_IF), 1);
        tick();

        // branch resolves on I-miss cycle 2, replayed at release
        for (int c = 1; c <= 5; c++) begin
            set_in(0, c == 2, 0, 0, 1, 0, 0);
            probe();
            chk("imiss_en", 32'(bus.PC_EN), 0);
            chk("imiss_hold", 32'(bus.Hold_Branch), (c >= 3) ? 1 : 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        probe();
        chk("replay_sel", 32'(bus.PC_Sel), 1);
        chk("replay_en", 32'(bus.PC_EN), 1);
        chk("replay_fi", 32'(bus.Flush_IF), 1);
        tick();

        // D-miss arrives exactly as the I-miss ends while a branch is pending
        set_in(0, 1, 0, 0, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 1, 0, 0); tick();
        for (int c = 0; c < 2; c++) begin
            set_in(0, 0, 0, 0, 0, 1, 0);
            probe();
            chk("dmiss_en", 32'(bus.PC_EN), 0);
            chk("dmiss_hold", 32'(bus.Hold_Branch), 1);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        probe();
        chk("dmiss_redir_sel", 32'(bus.PC_Sel), 1);
        chk("dmiss_redir_en", 32'(bus.PC_EN), 1);
        tick();
        probe(); chk("after_redir_hold", 32'(bus.Hold_Branch), 0); tick();

        // reset while a redirect is pending
        set_in(0, 1, 0, 0, 1, 0, 0); tick();
        set_in(1, 0, 0, 0, 1, 0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0);
        probe();
        chk("rst_pend_hold", 32'(bus.Hold_Branch), 0);
        chk("rst_pend_cnt", 32'(bus.Stall_Count), 0);
        chk("rst_pend_en", 32'(bus.PC_EN), 0);
        tick();

        // long D-miss saturates the stall counter
        set_in(0, 0, 0, 0, 0, 1, 0);
        repeat (40) tick();
        probe();
        chk("sat_count", 32'(bus.Stall_Count), CMAX);
        tick();

        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 199) == 0,
                   $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 25,
                   $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 15);
            tick();
        end

        check_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
